// File: rtl/round_controller.sv
// round_controller: sequences one two-player code-game round (P1 writes codes, P2 replays guesses).
// Defining TURN_TIMEOUT_EN builds a per-guess time limit; otherwise timeout is held at 0.
module round_controller #(
    parameter int unsigned DATA_W         = 10,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              next_pulse,
    input  logic              done_pulse,
    input  logic [DATA_W-1:0] p1_value,
    input  logic [DATA_W-1:0] p2_value,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              p1_active,
    output logic              p2_active,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   code_count,
    output logic [ADDR_W:0]   score,
    output logic              last_correct,
    output logic              round_done,
    output logic              timeout
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        P1_ENTRY = 3'd1,
        P2_FETCH = 3'd2,
        P2_WAIT  = 3'd3,
        P2_GUESS = 3'd4,
        RESULT   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                ram_wren_q, ram_wren_d;
    logic [CNT_W-1:0]    code_count_q, code_count_d;
    logic [CNT_W-1:0]    score_q, score_d;
    logic                last_correct_q, last_correct_d;
    logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0]   expected_q, expected_d;
    logic                timeout_q, timeout_d;
    logic                to_hit;

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Guess timer: zeroed on the way into P2_GUESS, counts every cycle spent there.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == P2_WAIT) begin
            to_cnt_d = '0;
        end else if (state_q == P2_GUESS) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // A real guess on the expiry edge takes precedence over the timeout.
    assign to_hit = (state_q == P2_GUESS) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))
                    && !next_pulse;
`else
    logic unused_timeout_cfg;

    assign to_hit             = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            ram_addr_q     <= '0;
            ram_data_q     <= '0;
            ram_wren_q     <= 1'b0;
            code_count_q   <= '0;
            score_q        <= '0;
            last_correct_q <= 1'b0;
            rd_idx_q       <= '0;
            expected_q     <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ram_addr_q     <= ram_addr_d;
            ram_data_q     <= ram_data_d;
            ram_wren_q     <= ram_wren_d;
            code_count_q   <= code_count_d;
            score_q        <= score_d;
            last_correct_q <= last_correct_d;
            rd_idx_q       <= rd_idx_d;
            expected_q     <= expected_d;
            timeout_q      <= timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ram_addr_d     = ram_addr_q;
        ram_data_d     = ram_data_q;
        ram_wren_d     = 1'b0;
        code_count_d   = code_count_q;
        score_d        = score_q;
        last_correct_d = last_correct_q;
        rd_idx_d       = rd_idx_q;
        expected_d     = expected_q;
        timeout_d      = 1'b0;

        case (state_q)
            IDLE, RESULT: begin
                if (start) begin
                    state_d        = P1_ENTRY;
                    code_count_d   = '0;
                    score_d        = '0;
                    last_correct_d = 1'b0;
                    rd_idx_d       = '0;
                end
            end
            P1_ENTRY: begin
                if (next_pulse && (code_count_q < CNT_W'(DEPTH))) begin
                    ram_addr_d   = ADDR_W'(code_count_q);
                    ram_data_d   = p1_value;
                    ram_wren_d   = 1'b1;
                    code_count_d = code_count_q + CNT_W'(1);
                end
                // A simultaneous next_pulse guarantees at least one code even from empty.
                if (done_pulse && ((code_count_q != '0) || next_pulse)) begin
                    state_d  = P2_FETCH;
                    rd_idx_d = '0;
                end
            end
            P2_FETCH: begin
                ram_addr_d = ADDR_W'(rd_idx_q);
                state_d    = P2_WAIT;
            end
            P2_WAIT: begin
                expected_d = ram_q;
                state_d    = P2_GUESS;
            end
            P2_GUESS: begin
                if (next_pulse || to_hit) begin
                    if (next_pulse) begin
                        last_correct_d = (p2_value == expected_q);
                        if ((p2_value == expected_q) && (score_q < code_count_q)) begin
                            score_d = score_q + CNT_W'(1);
                        end
                    end else begin
                        last_correct_d = 1'b0;
                        timeout_d      = 1'b1;
                    end
                    rd_idx_d = rd_idx_q + CNT_W'(1);
                    if ((rd_idx_d == code_count_q) || done_pulse) begin
                        state_d = RESULT;
                    end else begin
                        state_d = P2_FETCH;
                    end
                end else if (done_pulse) begin
                    state_d = RESULT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ram_addr     = ram_addr_q;
    assign ram_data     = ram_data_q;
    assign ram_wren     = ram_wren_q;
    assign p1_active    = (state_q == P1_ENTRY);
    assign p2_active    = (state_q == P2_GUESS);
    assign state        = state_q;
    assign code_count   = code_count_q;
    assign score        = score_q;
    assign last_correct = last_correct_q;
    assign round_done   = (state_q == RESULT);
    assign timeout      = timeout_q;

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
- Sequences one game round for the two-player code game.
- Player 1 enters a list of codes, which are written into the 32x10 code RAM. Player 2 then replays guesses, and each guess is compared against the stored code at the same index.
- Owns all RAM address, write-enable and data drive, and the player enables.
- Keeps the write count, the score and the per-guess correctness flag.

Parameters:
- DATA_W, 10, code width; matches the RAM word width.
- ADDR_W, 5, RAM address width.
- DEPTH, 32, maximum codes per round; must be at most 2**ADDR_W.
- TIMEOUT_CYCLES, 50000000, guess time limit in clock cycles. Used only with TURN_TIMEOUT_EN.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a round.
- next_pulse  in  1  one-cycle pulse; commit the current code (P1) or guess (P2).
- done_pulse  in  1  one-cycle pulse; end the current turn.
- p1_value  in  DATA_W  player 1 code.
- p2_value  in  DATA_W  player 2 guess.
- ram_q  in  DATA_W  RAM read data; valid 1 cycle after ram_addr is presented.
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_data  out  DATA_W  RAM write data (registered).
- ram_wren  out  1  RAM write enable (registered).
- p1_active  out  1  high in P1_ENTRY.
- p2_active  out  1  high in P2_GUESS.
- state  out  3  current state encoding, for the HEX debug display.
- code_count  out  ADDR_W+1  number of codes written this round.
- score  out  ADDR_W+1  number of correct guesses.
- last_correct  out  1  result of the most recent committed guess.
- round_done  out  1  high in RESULT.
- timeout  out  1  one-cycle pulse when a guess times out; tied 0 when the feature is off.

Behaviour:
- State encoding: IDLE=0, P1_ENTRY=1, P2_FETCH=2, P2_WAIT=3, P2_GUESS=4, RESULT=5.
- Reset: state=IDLE; every output register cleared to 0 (ram_addr, ram_data, ram_wren, code_count, score, last_correct, timeout); internal read index rd_idx=0.
- Reset has priority over all other inputs. Asserted mid-write, ram_wren is 0 from the next edge.

IDLE:
- start -> P1_ENTRY; clears code_count, score, last_correct and rd_idx.

P1_ENTRY:
- On an edge where next_pulse=1 and code_count<DEPTH: ram_addr<=code_count, ram_data<=p1_value, ram_wren<=1, code_count+=1.
- ram_wren is high for exactly one cycle per accepted pulse. Back-to-back pulses give consecutive writes.
- Full: when code_count==DEPTH, next_pulse is ignored (no write, count unchanged).
- done_pulse with code_count==0 is ignored.
- done_pulse with code_count>0 -> P2_FETCH, rd_idx=0.
- next_pulse and done_pulse on the same edge: the write is performed and the transition is taken in that same edge. The transition is taken even if code_count was 0 before the write.

P2_FETCH:
- ram_addr<=rd_idx, ram_wren=0 -> P2_WAIT.

P2_WAIT:
- ram_q becomes valid -> P2_GUESS; ram_q is captured into an internal expected register.

P2_GUESS:
- On next_pulse:
  - last_correct <= (p2_value==expected).
  - score increments if equal; score never exceeds code_count.
  - rd_idx+=1.
  - If the new rd_idx==code_count -> RESULT, else -> P2_FETCH.
- Guess-to-guess latency is 3 cycles; next_pulse during P2_FETCH or P2_WAIT is ignored.
- done_pulse alone -> RESULT; remaining codes are forfeited and score is unchanged.
- next_pulse and done_pulse together: the guess is scored first, then -> RESULT.

RESULT:
- round_done=1; score, code_count and last_correct are held.
- start -> P1_ENTRY with the same clears as from IDLE.

General:
- start is ignored in every state other than IDLE and RESULT.
- ram_wren is 0 in every state except during an accepted P1 write.
- rd_idx never exceeds code_count-1 when used as an address.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined: a cycle counter clears on every entry to P2_GUESS and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES-1 without a next_pulse, the guess is committed as incorrect: last_correct<=0, score unchanged, rd_idx advances as for next_pulse, and timeout pulses for 1 cycle.
  - A next_pulse on the same edge as the timeout wins; it is scored normally and timeout stays 0.
- Undefined: no counter is built; timeout is tied 0.

Test Plan:
- Reset then start; three next_pulses with p1_value 0x00A, 0x155, 0x3FF; then done_pulse -> RAM writes at addresses 0,1,2 with those data, one cycle of ram_wren each; code_count=3; state=2.
- Continue: guesses 0x00A, 0x000, 0x3FF -> last_correct sequence 1,0,1; score=2; round_done=1; state=5.
- 33 next_pulses in P1_ENTRY -> exactly 32 writes; code_count=32; 33rd pulse produces no write.
- done_pulse in P1_ENTRY with code_count=0 -> stays in state 1; then simultaneous next+done -> one write, code_count=1, then state 2.
- Mid-P2 done_pulse after 1 of 3 guesses -> RESULT with score<=1; reset asserted during a P1 write -> ram_wren=0 and state=0 at the next edge.
- With TURN_TIMEOUT_EN and TIMEOUT_CYCLES=8: idle in P2_GUESS -> timeout pulse 8 cycles after entry, last_correct=0, rd_idx advances.
